ddr3_reset_n_sequencer: RTL
===========================

// Module: ddr3_reset_n_sequencer
// PURPOSE
//  Sequences the DDR3 RESET_N pad IOD and its dynamic delay line. Holds DDR3 RESET_N low,
//  releases it after the JEDEC hold time, then enables CKE after the release wait.
//  Also serves delay-line trim requests (load/move) via a req/ack handshake.
//  Sits between the DDR PHY training/init controller and the RESET_N IOD lane.
// PARAMETERS
//  RST_LOW_CYCLES   33300  FAB_CLK cycles RESET_N held low (200 us @ 166.5 MHz)
//  CKE_WAIT_CYCLES  83250  FAB_CLK cycles from RESET_N release to CKE_EN (500 us)
//  CNT_W            17     width of the shared wait counter; must hold max(both counts)
// PORTS
//  FAB_CLK                   in   1  fabric clock, all logic rising-edge
//  ARST_N                    in   1  asynchronous active-low reset
//  INIT_START                in   1  pulse: begin power-up sequence (honoured only in S_IDLE)
//  SOFT_RESET_REQ            in   1  pulse: re-assert DDR3 reset and restart sequence
//  TX_DATA_0                 out  4  IOD TX nibble; all bits = RESET_N level
//  OE_DATA_0                 out  4  IOD output enable nibble
//  CKE_EN                    out  1  permits CKE drive to memory
//  INIT_DONE                 out  1  high in S_CKE_ON
//  SEQ_STATE                 out  2  current init state (debug)
//  DLY_REQ                   in   1  level: move request, held until DLY_ACK
//  DLY_DIR                   in   1  move direction, sampled at accept
//  DLY_STEPS                 in   8  number of moves, sampled at accept
//  DLY_LOAD_REQ              in   1  level: reload default delay, held until DLY_ACK
//  DLY_ACK                   out  1  one-cycle completion pulse
//  DLY_ERR                   out  1  last move command hit out-of-range
//  DELAY_LINE_MOVE_0         out  1  to IOD
//  DELAY_LINE_DIRECTION_0    out  1  to IOD
//  DELAY_LINE_LOAD_0         out  1  to IOD
//  DELAY_LINE_OUT_OF_RANGE_0 in   1  from IOD, synchronous to FAB_CLK
// BEHAVIOUR
//  Reset (ARST_N low, async): TX_DATA_0=4'b0000, OE_DATA_0=4'b1111 (pad driven low),
//   CKE_EN=0, INIT_DONE=0, SEQ_STATE=S_IDLE, all DELAY_LINE_*=0, DLY_ACK=0, DLY_ERR=0,
//   counter=0, delay FSM in D_IDLE. OE_DATA_0 is 4'b1111 in every state.
//  Init FSM (SEQ_STATE encoding 0..3):
//   S_IDLE: TX=0000. INIT_START -> S_HOLD, counter cleared.
//   S_HOLD: TX=0000; counter increments; at count RST_LOW_CYCLES-1 -> S_WAIT, counter cleared.
//   S_WAIT: TX=1111; at count CKE_WAIT_CYCLES-1 -> S_CKE_ON.
//   S_CKE_ON: TX=1111, CKE_EN=1, INIT_DONE=1; stays until soft reset.
//   => TX goes 1111 exactly RST_LOW_CYCLES cycles after entering S_HOLD; CKE_EN rises
//      exactly CKE_WAIT_CYCLES cycles after TX goes 1111. All outputs registered.
//  SOFT_RESET_REQ in S_HOLD/S_WAIT/S_CKE_ON: next edge -> S_HOLD, counter=0, TX=0000,
//   CKE_EN=0, INIT_DONE=0. In S_IDLE it acts as INIT_START. Wins over INIT_START if both high.
//  INIT_START outside S_IDLE: ignored.
//  Delay FSM (independent of init FSM): D_IDLE, D_MOVE, D_GAP, D_ACK.
//   Accept in D_IDLE when DLY_LOAD_REQ or DLY_REQ high and DLY_ACK low; LOAD has priority.
//   LOAD accept (cycle A): DELAY_LINE_LOAD_0=1 in cycle A+1 only; DLY_ACK in A+2;
//    DLY_ERR cleared.
//   Move accept (cycle A): latch DIR/STEPS, clear DLY_ERR; DELAY_LINE_DIRECTION_0=DLY_DIR
//    from A+1 until the next move accept (held stable across all pulses).
//    DLY_STEPS=0: DLY_ACK in A+1, no pulses.
//    N>0: DELAY_LINE_MOVE_0 high in A+2, A+4, ..., A+2N (D_MOVE), low between (D_GAP);
//    DLY_ACK one cycle in A+2N+1.
//   Out-of-range: OUT_OF_RANGE_0 high in a D_GAP cycle -> remaining steps abandoned,
//    DLY_ACK next cycle with DLY_ERR=1 (same edge). DLY_ERR sticky until next accept.
//   Requester drops REQ the cycle after DLY_ACK; REQ high during the DLY_ACK cycle is
//    not re-accepted.
//  ARST_N mid-sequence or mid-move: immediate return to reset values; no ACK issued.
// TESTING (RST_LOW_CYCLES=10, CKE_WAIT_CYCLES=20)
//  1 Reset release, INIT_START at cycle 0 -> TX=0000 to cycle 10, TX=1111 from 11,
//    CKE_EN/INIT_DONE=1 from cycle 31; OE_DATA_0=1111 throughout.
//  2 SOFT_RESET_REQ at cycle 20 of S_WAIT -> TX=0000, CKE_EN=0 next cycle; TX=1111
//    10 cycles later; CKE_EN 20 cycles after that.
//  3 DLY_REQ DIR=1 STEPS=3 accepted at A -> DIRECTION=1 from A+1, MOVE at A+2/A+4/A+6,
//    ACK at A+7, DLY_ERR=0.
//  4 STEPS=5, OUT_OF_RANGE forced high after 2nd MOVE -> exactly 2 MOVE pulses, ACK+ERR=1;
//    next LOAD -> LOAD pulse 1 cycle, ACK, ERR=0.
//  5 DLY_LOAD_REQ and DLY_REQ same cycle -> LOAD serviced first, then move; STEPS=0 ->
//    ACK at A+1, no MOVE.
//  6 ARST_N pulsed low during move train and during S_WAIT -> all outputs at reset values
//    asynchronously, no spurious ACK after release.

Source files
------------

// File: rtl/ddr3_reset_n_sequencer.sv
// ddr3_reset_n_sequencer
// Drives the DDR3 RESET_N pad IOD through the power-up sequence: RESET_N low
// for the hold time, released, then CKE enabled after the release wait. A
// second, independent FSM serves delay-line trim requests (load / move) for
// the RESET_N lane through a level req / one-cycle ack handshake.
// All outputs come straight from flops.

module ddr3_reset_n_sequencer #(
  parameter int RST_LOW_CYCLES  = 33300,
  parameter int CKE_WAIT_CYCLES = 83250,
  parameter int CNT_W           = 17
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       INIT_START,
  input  logic       SOFT_RESET_REQ,
  output logic [3:0] TX_DATA_0,
  output logic [3:0] OE_DATA_0,
  output logic       CKE_EN,
  output logic       INIT_DONE,
  output logic [1:0] SEQ_STATE,
  input  logic       DLY_REQ,
  input  logic       DLY_DIR,
  input  logic [7:0] DLY_STEPS,
  input  logic       DLY_LOAD_REQ,
  output logic       DLY_ACK,
  output logic       DLY_ERR,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       DELAY_LINE_LOAD_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0
);

  // Init FSM encoding (also exported on SEQ_STATE)
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_CKE_ON = 2'd3;

  // Delay FSM encoding
  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_MOVE = 2'd1;
  localparam logic [1:0] D_GAP  = 2'd2;
  localparam logic [1:0] D_ACK  = 2'd3;

  // Terminal counts; the counter starts at zero on entry to each timed state
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CKE_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // RESET_N level replicated across the TX nibble
  function automatic logic [3:0] reset_n_nibble(input logic [1:0] st);
    logic [3:0] nib;
    case (st)
      S_WAIT:   nib = 4'b1111;
      S_CKE_ON: nib = 4'b1111;
      S_IDLE:   nib = 4'b0000;
      S_HOLD:   nib = 4'b0000;
      default:  nib = 4'b0000;
    endcase
    return nib;
  endfunction

  // ---------------------------------------------------------------------------
  // Init sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tx_q;
  logic [3:0]       oe_q;
  logic             cke_q;
  logic             done_q;

  // Init next-state: soft reset restarts the hold from any state and wins over start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (SOFT_RESET_REQ || INIT_START) begin
          state_d = S_HOLD;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      S_HOLD: begin
        if (SOFT_RESET_REQ) begin
          state_d = S_HOLD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (SOFT_RESET_REQ) begin
          state_d = S_HOLD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_CKE_ON;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_CKE_ON: begin
        if (SOFT_RESET_REQ) begin
          state_d = S_HOLD;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_CKE_ON;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Init state, counter and pad/CKE outputs, decoded from the next state so they align with it
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      tx_q    <= 4'b0000;
      oe_q    <= 4'b1111;
      cke_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= reset_n_nibble(state_d);
      oe_q    <= 4'b1111;
      cke_q   <= (state_d == S_CKE_ON);
      done_q  <= (state_d == S_CKE_ON);
    end
  end

  assign TX_DATA_0 = tx_q;
  assign OE_DATA_0 = oe_q;
  assign CKE_EN    = cke_q;
  assign INIT_DONE = done_q;
  assign SEQ_STATE = state_q;

  // ---------------------------------------------------------------------------
  // Delay-line trim engine
  // ---------------------------------------------------------------------------
  logic [1:0] dstate_q, dstate_d;
  logic [7:0] steps_q, steps_d;
  logic       is_load_q, is_load_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;
  logic       move_q, move_d;
  logic       load_q, load_d;
  logic       ack_q, ack_d;
  logic       accept_ok_s;

  // Requests are only taken in D_IDLE and never in an ack cycle
  assign accept_ok_s = (dstate_q == D_IDLE) && !ack_q;

  // Delay next-state: load uses one D_GAP cycle for its pulse; moves alternate D_GAP / D_MOVE
  always_comb begin
    dstate_d  = dstate_q;
    steps_d   = steps_q;
    is_load_d = is_load_q;
    dir_d     = dir_q;
    err_d     = err_q;
    move_d    = 1'b0;
    load_d    = 1'b0;
    ack_d     = 1'b0;
    case (dstate_q)
      D_IDLE: begin
        if (accept_ok_s && DLY_LOAD_REQ) begin
          dstate_d  = D_GAP;
          steps_d   = 8'd0;
          is_load_d = 1'b1;
          load_d    = 1'b1;
          err_d     = 1'b0;
        end else if (accept_ok_s && DLY_REQ) begin
          is_load_d = 1'b0;
          dir_d     = DLY_DIR;
          err_d     = 1'b0;
          if (DLY_STEPS == 8'd0) begin
            dstate_d = D_ACK;
            steps_d  = 8'd0;
            ack_d    = 1'b1;
          end else begin
            dstate_d = D_GAP;
            steps_d  = DLY_STEPS;
          end
        end else begin
          dstate_d = D_IDLE;
        end
      end
      D_GAP: begin
        if (!is_load_q && DELAY_LINE_OUT_OF_RANGE_0) begin
          // Abandon the remaining steps; error and ack land on the same edge
          dstate_d = D_ACK;
          steps_d  = 8'd0;
          err_d    = 1'b1;
          ack_d    = 1'b1;
        end else if (steps_q != 8'd0) begin
          dstate_d = D_MOVE;
          steps_d  = steps_q - 8'd1;
          move_d   = 1'b1;
        end else begin
          dstate_d = D_ACK;
          ack_d    = 1'b1;
        end
      end
      D_MOVE: begin
        if (steps_q == 8'd0) begin
          dstate_d = D_ACK;
          ack_d    = 1'b1;
        end else begin
          dstate_d = D_GAP;
        end
      end
      D_ACK: begin
        dstate_d = D_IDLE;
      end
      default: begin
        dstate_d = D_IDLE;
        steps_d  = 8'd0;
      end
    endcase
  end

  // Delay engine state and IOD control flops
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      dstate_q  <= D_IDLE;
      steps_q   <= 8'd0;
      is_load_q <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      move_q    <= 1'b0;
      load_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      dstate_q  <= dstate_d;
      steps_q   <= steps_d;
      is_load_q <= is_load_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      move_q    <= move_d;
      load_q    <= load_d;
      ack_q     <= ack_d;
    end
  end

  assign DLY_ACK                = ack_q;
  assign DLY_ERR                = err_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;
  assign DELAY_LINE_LOAD_0      = load_q;

endmodule
